// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types and constants for the SRAM bus arbiter: FSM states, port ids and bus widths.
`timescale 1ns/1ps
package sram_bus_arbiter_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int CPU_ADDR_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ACT   = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_ACT   = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  typedef enum logic {
    PORT_IF  = 1'b0,
    PORT_MEM = 1'b1
  } port_t;

  // A zero-wait configuration still needs a one-bit counter to stay legal.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the single off-chip SRAM bus between instruction fetch and MEM-stage data
// accesses, sequencing CE/OE/WE with a per-access FSM and stalling the losing requester.
`timescale 1ns/1ps
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [CPU_ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_ack,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [CPU_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_ack,
  output logic                  stall_if,
  output logic                  stall_mem,
  output logic                  bus_err,
  output logic [ADDR_W-1:0]     sram_addr,
  inout  wire  [DATA_W-1:0]     sram_data,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  localparam int              CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  state_t              state_q, state_d;
  port_t               port_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                strobe_last;
  logic                mem_any;
  logic                grant;
  logic                drive_en;

  assign mem_any     = mem_read | mem_write;
  assign strobe_last = (cnt_q == CNT_LAST);
  assign grant       = (state_q == ST_IDLE) && (mem_any || if_req);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned
  // (otherwise a latch would be inferred).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_write)              state_d = ST_WR_SETUP;
        else if (mem_read || if_req) state_d = ST_RD_ACT;
      end
      ST_RD_ACT:   if (strobe_last) state_d = ST_DONE;
      ST_WR_SETUP: state_d = ST_WR_ACT;
      ST_WR_ACT:   if (strobe_last) state_d = ST_WR_HOLD;
      ST_WR_HOLD:  state_d = ST_DONE;
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    drive_en  = 1'b0;
    if_ack    = 1'b0;
    mem_ack   = 1'b0;
    unique case (state_q)
      ST_RD_ACT: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        sram_ce_n = 1'b0;
        drive_en  = 1'b1;
      end
      ST_WR_ACT: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        drive_en  = 1'b1;
      end
      ST_DONE: begin
        if_ack  = (port_q == PORT_IF);
        mem_ack = (port_q == PORT_MEM);
      end
      default: ;
    endcase
  end

  // Strobe counter plus the latched winner; the access in flight ignores later input changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      port_q    <= PORT_IF;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if ((state_q == ST_RD_ACT || state_q == ST_WR_ACT) && !strobe_last)
        cnt_q <= cnt_q + CNT_W'(1);
      else
        cnt_q <= '0;

      if (grant) begin
        port_q  <= mem_any ? PORT_MEM : PORT_IF;
        addr_q  <= ADDR_W'(mem_any ? mem_addr : if_addr);
        wdata_q <= mem_wdata;
      end

      if (state_q == ST_RD_ACT && strobe_last) begin
        if (port_q == PORT_IF) if_rdata  <= sram_data;
        else                   mem_rdata <= sram_data;
      end
    end
  end

  assign sram_addr = addr_q;
  assign sram_data = drive_en ? wdata_q : {DATA_W{1'bz}};

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = mem_any & ~mem_ack;
  assign bus_err   = ~rst & (state_q == ST_IDLE) & mem_read & mem_write;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with a behavioural asynchronous SRAM on the shared bus.
`timescale 1ns/1ps
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;
  logic [17:0] sram_addr;
  wire  [15:0] sram_data;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  // SRAM model: reads drive the bus while CE/OE are low; a write commits only after
  // WE has been held low for a full two-cycle strobe.
  logic [15:0] mem [0:1023];
  logic        preloaded = 1'b0;
  int          wr_low = 0;
  logic [17:0] wr_addr;
  logic [15:0] wr_data;

  function automatic logic [9:0] idx(input logic [17:0] a);
    return {a[15], a[8:0]};
  endfunction

  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[idx(sram_addr)] : 16'hzzzz;

  always @(negedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[idx(18'h00040)] = 16'h4A01;
      mem[idx(18'h00100)] = 16'h1111;
      mem[idx(18'h00041)] = 16'h2222;
      mem[idx(18'h00043)] = 16'h5555;
      for (int i = 0; i < 4; i++) mem[idx(18'(i))] = 16'hA000 + 16'(i);
      preloaded = 1'b1;
    end
    if (!sram_ce_n && !sram_we_n) begin
      wr_low++;
      wr_addr = sram_addr;
      wr_data = sram_data;
    end else begin
      if (wr_low >= 2) mem[idx(wr_addr)] = wr_data;
      wr_low = 0;
    end
  end

  // Undriven reads back as Z on four-state simulators and as 0 on two-state ones.
  function automatic logic bus_released(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
      errors++; $display("FAIL reset_strobes: got %b expected 111", {sram_ce_n, sram_oe_n, sram_we_n});
    end
    checks++;
    if (sram_addr !== 18'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 00000", sram_addr);
    end
    checks++;
    if ({if_ack, mem_ack, bus_err} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 000", {if_ack, mem_ack, bus_err});
    end
    checks++;
    if (if_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_if_rdata: got %h expected 0000", if_rdata);
    end
    checks++;
    if (mem_rdata !== 16'h0) begin
      errors++; $display("FAIL reset_mem_rdata: got %h expected 0000", mem_rdata);
    end
    checks++;
    if (!bus_released(sram_data)) begin
      errors++; $display("FAIL reset_bus: got %h expected released", sram_data);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    int          ack_k = -1;
    int          oe_cnt = 0;
    logic        stall0 = 1'b0;
    logic        we_seen = 1'b0;
    logic [15:0] data = 16'h0;
    logic [17:0] addr1 = 18'h0;
    if_req  = 1'b1;
    if_addr = 16'h0040;
    for (int k = 0; k < 8; k++) begin
      logic ackd;
      @(negedge clk);
      ackd = if_ack;
      if (k == 0) stall0 = stall_if;
      if (k == 1) addr1 = sram_addr;
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_seen = 1'b1;
      if (ackd && ack_k < 0) begin ack_k = k; data = if_rdata; end
      next_cycle();
      if (ackd) if_req = 1'b0;
    end
    checks++;
    if (ack_k != 3) begin errors++; $display("FAIL fetch_ack_cycle: got %0d expected 3", ack_k); end
    checks++;
    if (data !== 16'h4A01) begin errors++; $display("FAIL fetch_rdata: got %h expected 4a01", data); end
    checks++;
    if (oe_cnt != 2) begin errors++; $display("FAIL fetch_oe_len: got %0d expected 2", oe_cnt); end
    checks++;
    if (stall0 !== 1'b1) begin errors++; $display("FAIL fetch_stall: got %b expected 1", stall0); end
    checks++;
    if (we_seen !== 1'b0) begin errors++; $display("FAIL fetch_we: got %b expected 0", we_seen); end
    checks++;
    if (addr1 !== 18'h00040) begin errors++; $display("FAIL fetch_addr: got %h expected 00040", addr1); end
  endtask

  task automatic test_store;
    logic [9:0]  we_mask = '0;
    logic [9:0]  ce_mask = '0;
    logic        oe_seen = 1'b0;
    int          drv_cnt = 0;
    int          ack_k = -1;
    logic        stall0 = 1'b0;
    logic [17:0] addr1 = 18'h0;
    mem_write = 1'b1;
    mem_addr  = 16'h8000;
    mem_wdata = 16'hBEEF;
    for (int k = 0; k < 10; k++) begin
      logic ackd;
      @(negedge clk);
      ackd = mem_ack;
      we_mask[k] = ~sram_we_n;
      ce_mask[k] = ~sram_ce_n;
      if (!sram_oe_n) oe_seen = 1'b1;
      if (k >= 1 && k <= 4 && sram_data === 16'hBEEF) drv_cnt++;
      if (k == 0) stall0 = stall_mem;
      if (k == 1) addr1 = sram_addr;
      if (ackd && ack_k < 0) ack_k = k;
      next_cycle();
      if (ackd) mem_write = 1'b0;
    end
    checks++;
    if (we_mask !== 10'b0000001100) begin errors++; $display("FAIL store_we: got %b expected 0000001100", we_mask); end
    checks++;
    if (ce_mask !== 10'b0000011110) begin errors++; $display("FAIL store_ce: got %b expected 0000011110", ce_mask); end
    checks++;
    if (oe_seen !== 1'b0) begin errors++; $display("FAIL store_oe: got %b expected 0", oe_seen); end
    checks++;
    if (drv_cnt != 4) begin errors++; $display("FAIL store_drive: got %0d cycles expected 4", drv_cnt); end
    checks++;
    if (ack_k != 5) begin errors++; $display("FAIL store_ack_cycle: got %0d expected 5", ack_k); end
    checks++;
    if (stall0 !== 1'b1) begin errors++; $display("FAIL store_stall: got %b expected 1", stall0); end
    checks++;
    if (addr1 !== 18'h08000) begin errors++; $display("FAIL store_addr: got %h expected 08000", addr1); end
    checks++;
    if (mem[idx(18'h08000)] !== 16'hBEEF) begin
      errors++; $display("FAIL store_model: got %h expected beef", mem[idx(18'h08000)]);
    end
  endtask

  task automatic test_conflict;
    int          mem_k = -1;
    int          if_k = -1;
    logic [15:0] mdata = 16'h0;
    logic [15:0] idata = 16'h0;
    logic [11:0] stall_mask = '0;
    if_req    = 1'b1;
    if_addr   = 16'h0100;
    mem_read  = 1'b1;
    mem_addr  = 16'h0041;
    mem_wdata = 16'h0000;
    for (int k = 0; k < 12; k++) begin
      logic m_ackd, i_ackd;
      @(negedge clk);
      m_ackd = mem_ack;
      i_ackd = if_ack;
      stall_mask[k] = stall_if;
      if (m_ackd && mem_k < 0) begin mem_k = k; mdata = mem_rdata; end
      if (i_ackd && if_k < 0) begin if_k = k; idata = if_rdata; end
      next_cycle();
      if (m_ackd) mem_read = 1'b0;
      if (i_ackd) if_req = 1'b0;
    end
    checks++;
    if (mem_k != 3) begin errors++; $display("FAIL conflict_mem_ack: got %0d expected 3", mem_k); end
    checks++;
    if (mdata !== 16'h2222) begin errors++; $display("FAIL conflict_mem_rdata: got %h expected 2222", mdata); end
    checks++;
    if (if_k != 7) begin errors++; $display("FAIL conflict_if_ack: got %0d expected 7", if_k); end
    checks++;
    if (idata !== 16'h1111) begin errors++; $display("FAIL conflict_if_rdata: got %h expected 1111", idata); end
    checks++;
    if (stall_mask !== 12'h07F) begin errors++; $display("FAIL conflict_stall_if: got %h expected 07f", stall_mask); end
  endtask

  task automatic test_reset_abort;
    logic       we_low2 = 1'b0;
    logic [2:0] strobes3 = 3'b000;
    logic       released3 = 1'b0;
    int         ack_cnt = 0;
    mem_write = 1'b1;
    mem_addr  = 16'h0043;
    mem_wdata = 16'hAAAA;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (mem_ack) ack_cnt++;
      if (k == 2) we_low2 = ~sram_we_n;
      if (k == 3) begin
        strobes3  = {sram_ce_n, sram_oe_n, sram_we_n};
        released3 = bus_released(sram_data);
      end
      next_cycle();
      if (k == 1) begin rst = 1'b1; mem_write = 1'b0; end
      if (k == 2) rst = 1'b0;
    end
    checks++;
    if (we_low2 !== 1'b1) begin errors++; $display("FAIL abort_we_active: got %b expected 1", we_low2); end
    checks++;
    if (strobes3 !== 3'b111) begin errors++; $display("FAIL abort_strobes: got %b expected 111", strobes3); end
    checks++;
    if (released3 !== 1'b1) begin errors++; $display("FAIL abort_bus: got %b expected released", released3); end
    checks++;
    if (ack_cnt != 0) begin errors++; $display("FAIL abort_ack: got %0d acks expected 0", ack_cnt); end
    checks++;
    if (mem[idx(18'h00043)] !== 16'h5555) begin
      errors++; $display("FAIL abort_model: got %h expected 5555", mem[idx(18'h00043)]);
    end
  endtask

  task automatic test_bus_err;
    logic [9:0] err_mask = '0;
    int         ack_cnt = 0;
    int         ack_k = -1;
    int         we_cnt = 0;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 16'h0042;
    mem_wdata = 16'h1234;
    for (int k = 0; k < 10; k++) begin
      logic ackd;
      @(negedge clk);
      ackd = mem_ack;
      err_mask[k] = bus_err;
      if (!sram_we_n) we_cnt++;
      if (ackd) begin ack_cnt++; if (ack_k < 0) ack_k = k; end
      next_cycle();
      if (ackd) begin mem_read = 1'b0; mem_write = 1'b0; end
    end
    checks++;
    if (err_mask !== 10'b0000000001) begin errors++; $display("FAIL buserr_pulse: got %b expected 0000000001", err_mask); end
    checks++;
    if (ack_cnt != 1 || ack_k != 5) begin
      errors++; $display("FAIL buserr_ack: got %0d acks first at %0d expected 1 at 5", ack_cnt, ack_k);
    end
    checks++;
    if (we_cnt != 2) begin errors++; $display("FAIL buserr_we_len: got %0d expected 2", we_cnt); end
    checks++;
    if (mem[idx(18'h00042)] !== 16'h1234) begin
      errors++; $display("FAIL buserr_model: got %h expected 1234", mem[idx(18'h00042)]);
    end
  endtask

  task automatic test_back_to_back;
    int          ack_k [4];
    logic [15:0] got [4];
    int          n = 0;
    int          bus_bad = 0;
    int          we_cnt = 0;
    for (int i = 0; i < 4; i++) begin ack_k[i] = -1; got[i] = 16'h0; end
    if_req  = 1'b1;
    if_addr = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      logic ackd;
      @(negedge clk);
      ackd = if_ack;
      if (sram_oe_n && !bus_released(sram_data)) bus_bad++;
      if (!sram_we_n) we_cnt++;
      if (ackd && n < 4) begin ack_k[n] = k; got[n] = if_rdata; n++; end
      next_cycle();
      if (ackd) begin
        if (n >= 4) if_req = 1'b0;
        else        if_addr = 16'(n);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ack_k[i] != 3 + 4 * i) begin
        errors++; $display("FAIL b2b_ack_cycle[%0d]: got %0d expected %0d", i, ack_k[i], 3 + 4 * i);
      end
      checks++;
      if (got[i] !== 16'hA000 + 16'(i)) begin
        errors++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", i, got[i], 16'hA000 + 16'(i));
      end
    end
    checks++;
    if (bus_bad != 0) begin errors++; $display("FAIL b2b_bus_driven: got %0d cycles expected 0", bus_bad); end
    checks++;
    if (we_cnt != 0) begin errors++; $display("FAIL b2b_we: got %0d cycles expected 0", we_cnt); end
  endtask

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = 16'h0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 16'h0;
    mem_wdata = 16'h0;
    test_reset();
    test_fetch();
    test_store();
    test_conflict();
    test_reset_abort();
    test_bus_err();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
